// File: rtl/robot_path_sequencer_if.sv
// Operator/programming bundle for robot_path_sequencer: board inputs in, verdict and display drive out.
interface robot_path_sequencer_if #(
  parameter int DIGIT_W = 4
);
  logic               prog_en;
  logic [2:0]         prog_addr;
  logic [DIGIT_W-1:0] prog_data;
  logic               start;
  logic               insere;
  logic [DIGIT_W-1:0] path_input;
  logic               busy;
  logic [2:0]         step_counter;
  logic [2:0]         error_count;
  logic [1:0]         result;
  logic               result_valid;
  logic               done_pulse;
  logic [DIGIT_W-1:0] last_digit;
  logic               led_error;

  modport master (
    output prog_en, prog_addr, prog_data, start, insere, path_input,
    input  busy, step_counter, error_count, result, result_valid,
           done_pulse, last_digit, led_error
  );

  modport slave (
    input  prog_en, prog_addr, prog_data, start, insere, path_input,
    output busy, step_counter, error_count, result, result_valid,
           done_pulse, last_digit, led_error
  );
endinterface

// File: rtl/robot_path_sequencer.sv
// Runs robot-path attempts against a programmable digit sequence and issues an S/P/F verdict.
// Submissions are rising edges of insere; idle time in RUN is charged as an error after a timeout.
module robot_path_sequencer #(
  parameter int PATH_LEN       = 6,
  parameter int MAX_ERRORS     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DIGIT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  robot_path_sequencer_if.slave bus
);
  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         STEP_MAX   = 3'(PATH_LEN);
  localparam logic [2:0]         ERR_MAX    = 3'(MAX_ERRORS);
  localparam logic [3:0]         ADDR_LIMIT = 4'(PATH_LEN);

  localparam logic [1:0] RES_S    = 2'b00;
  localparam logic [1:0] RES_P    = 2'b01;
  localparam logic [1:0] RES_F    = 2'b10;
  localparam logic [1:0] RES_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg;
  logic                 insere_q_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [2:0]           step_reg;
  logic [2:0]           err_reg;
  logic [1:0]           result_reg;
  logic                 result_valid_reg;
  logic                 done_pulse_reg;
  logic                 busy_reg;
  logic [DIGIT_W-1:0]   last_digit_reg;
  logic                 led_error_reg;
  logic [DIGIT_W-1:0]   mem_reg [8];

  logic       submit;
  logic       digit_match;
  logic       timeout_hit;
  logic       charge_error;
  logic       wr_ok;
  logic [2:0] step_inc;
  logic [2:0] err_inc;
  logic [7:0] mem_we;

  // Factory path restored on every reset: 5,9,0,0,6,0 with unused slots zero.
  function automatic logic [DIGIT_W-1:0] default_digit(input int idx);
    case (idx)
      0:       return DIGIT_W'(5);
      1:       return DIGIT_W'(9);
      4:       return DIGIT_W'(6);
      default: return '0;
    endcase
  endfunction

  assign submit       = (state_reg == RUN) && bus.insere && !insere_q_reg;
  assign digit_match  = (bus.path_input == mem_reg[step_reg]);
  assign timeout_hit  = (state_reg == RUN) && !submit && (timer_reg == TIMER_LAST);
  assign charge_error = (submit && !digit_match) || timeout_hit;
  assign step_inc     = step_reg + 3'd1;
  assign err_inc      = err_reg + 3'd1;
  assign wr_ok        = bus.prog_en && (state_reg != RUN) && ({1'b0, bus.prog_addr} < ADDR_LIMIT);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mem_we
      assign mem_we[gi] = wr_ok && (bus.prog_addr == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset) begin
        mem_reg[i] <= default_digit(i);
      end else if (mem_we[i]) begin
        mem_reg[i] <= bus.prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      insere_q_reg     <= 1'b0;
      timer_reg        <= '0;
      step_reg         <= '0;
      err_reg          <= '0;
      result_reg       <= RES_NONE;
      result_valid_reg <= 1'b0;
      done_pulse_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      last_digit_reg   <= '0;
      led_error_reg    <= 1'b1;
    end else begin
      insere_q_reg   <= bus.insere;
      done_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          // A write cycle always wins over start so programming can't launch an attempt.
          if (bus.start && !bus.prog_en) begin
            state_reg        <= RUN;
            busy_reg         <= 1'b1;
            result_valid_reg <= 1'b0;
            step_reg         <= '0;
            err_reg          <= '0;
            timer_reg        <= '0;
            result_reg       <= RES_NONE;
            led_error_reg    <= 1'b1;
          end
        end
        RUN: begin
          if (submit) begin
            last_digit_reg <= bus.path_input;
          end
          if (charge_error) begin
            err_reg       <= err_inc;
            led_error_reg <= 1'b0;
            timer_reg     <= '0;
            if (err_inc == ERR_MAX) begin
              state_reg        <= DONE;
              busy_reg         <= 1'b0;
              result_valid_reg <= 1'b1;
              done_pulse_reg   <= 1'b1;
              result_reg       <= RES_F;
            end
          end else if (submit) begin
            step_reg  <= step_inc;
            timer_reg <= '0;
            if (step_inc == STEP_MAX) begin
              state_reg        <= DONE;
              busy_reg         <= 1'b0;
              result_valid_reg <= 1'b1;
              done_pulse_reg   <= 1'b1;
              result_reg       <= (err_reg == 3'd0) ? RES_S : RES_P;
              led_error_reg    <= (err_reg == 3'd0);
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_reg;
  assign bus.step_counter = step_reg;
  assign bus.error_count  = err_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.done_pulse   = done_pulse_reg;
  assign bus.last_digit   = last_digit_reg;
  assign bus.led_error    = led_error_reg;
endmodule
